// File: rtl/mem_access_stage.sv
// mem_access_stage: MEM-stage load/store unit with a req/ack data port,
// upstream stall, word-alignment check and ack timeout.
module mem_access_stage #(
  parameter int MAX_WAIT = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        MemRead_i,
  input  logic        MemWrite_i,
  input  logic [1:0]  WB_i,
  input  logic [31:0] ALUResult_i,
  input  logic [31:0] WriteData_i,
  input  logic [4:0]  RegAddr_i,
  output logic [1:0]  WB_o,
  output logic [31:0] MemData_o,
  output logic [31:0] RegData_o,
  output logic [4:0]  RegAddr_o,
  output logic        stall_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  output logic        err_o
);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  localparam logic [7:0] CntLast = 8'(MAX_WAIT - 1);

  state_t      state, stateNext;
  logic [7:0]  cnt;
  logic [1:0]  wbQ;
  logic [31:0] dataQ;
  logic [31:0] aluQ;
  logic [4:0]  regQ;
  logic        acc;
  logic        misal;
  logic        tmo;

  assign acc   = MemRead_i | MemWrite_i;
  assign misal = acc & (|ALUResult_i[1:0]);
  assign tmo   = (state == BUSY) & ~mem_ack_i & (cnt == CntLast);

  always_comb begin
    stateNext = state;
    WB_o      = 2'b00;
    MemData_o = '0;
    RegData_o = '0;
    RegAddr_o = '0;
    stall_o   = 1'b0;
    if (rst_ni) begin
      unique case (state)
        IDLE: begin
          RegData_o = ALUResult_i;
          RegAddr_o = RegAddr_i;
          WB_o      = acc ? 2'b00 : WB_i;
          stall_o   = acc & ~misal;
          if (acc & ~misal) stateNext = BUSY;
        end
        BUSY: begin
          stall_o   = 1'b1;
          RegData_o = aluQ;
          RegAddr_o = regQ;
          if (mem_ack_i | tmo) stateNext = DONE;
        end
        DONE: begin
          WB_o      = wbQ;
          MemData_o = dataQ;
          RegData_o = aluQ;
          RegAddr_o = regQ;
          stateNext = IDLE;
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state       <= IDLE;
      cnt         <= '0;
      wbQ         <= '0;
      dataQ       <= '0;
      aluQ        <= '0;
      regQ        <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      err_o       <= 1'b0;
    end else begin
      state <= stateNext;
      unique case (state)
        IDLE: begin
          if (misal) begin
            err_o <= 1'b1;
          end else if (acc) begin
            wbQ         <= WB_i;
            aluQ        <= ALUResult_i;
            regQ        <= RegAddr_i;
            dataQ       <= '0;
            mem_we_o    <= MemWrite_i;
            mem_addr_o  <= {ALUResult_i[31:2], 2'b00};
            mem_wdata_o <= WriteData_i;
            mem_req_o   <= 1'b1;
            cnt         <= '0;
          end
        end
        BUSY: begin
          if (mem_ack_i) begin
            mem_req_o <= 1'b0;
            dataQ     <= mem_we_o ? 32'h0 : mem_rdata_i;
          end else if (tmo) begin
            // abandoned access must not write back
            mem_req_o <= 1'b0;
            dataQ     <= 32'hDEADBEEF;
            wbQ       <= 2'b00;
            err_o     <= 1'b1;
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// tb_mem_access_stage: scoreboard bench with a memory responder and a
// transaction-level model of each instruction's writeback and stall.
module tb_mem_access_stage;

  localparam int MW = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        MemRead_i = 1'b0;
  logic        MemWrite_i = 1'b0;
  logic [1:0]  WB_i = '0;
  logic [31:0] ALUResult_i = '0;
  logic [31:0] WriteData_i = '0;
  logic [4:0]  RegAddr_i = '0;
  logic [1:0]  WB_o;
  logic [31:0] MemData_o;
  logic [31:0] RegData_o;
  logic [4:0]  RegAddr_o;
  logic        stall_o;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i = 1'b0;
  logic [31:0] mem_rdata_i = '0;
  logic        err_o;

  mem_access_stage #(.MAX_WAIT(MW)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .MemRead_i(MemRead_i), .MemWrite_i(MemWrite_i),
    .WB_i(WB_i), .ALUResult_i(ALUResult_i),
    .WriteData_i(WriteData_i), .RegAddr_i(RegAddr_i),
    .WB_o(WB_o), .MemData_o(MemData_o),
    .RegData_o(RegData_o), .RegAddr_o(RegAddr_o),
    .stall_o(stall_o), .mem_req_o(mem_req_o),
    .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i),
    .mem_rdata_i(mem_rdata_i), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [1:0]  wb;
    logic [31:0] md;
    logic [31:0] rd;
    logic [4:0]  ra;
    int          stallLen;
    bit          chkData;
    bit          setErr;
    bit          tmo;
  } exp_t;

  exp_t q[$];
  exp_t mExp;
  int vectors = 0;
  int miscompares = 0;
  bit errSticky = 1'b0;
  int ackDelay = 0;
  int expReqLen = 0;
  logic [31:0] ackData = '0;
  logic [31:0] expAddr = '0;
  logic [31:0] expWdata = '0;
  logic expWe = 1'b0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  // monitor: one retirement per stall-free cycle while work is queued
  int stallCnt = 0;
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      stallCnt = 0;
    end else if (stall_o) begin
      stallCnt++;
      chk("bubble_wb", 32'(WB_o), 32'h0);
    end else begin
      if (q.size() > 0) begin
        mExp = q.pop_front();
        chk("ret_wb", 32'(WB_o), 32'(mExp.wb));
        if (mExp.chkData) begin
          chk("ret_memdata", MemData_o, mExp.md);
          chk("ret_regdata", RegData_o, mExp.rd);
          chk("ret_regaddr", 32'(RegAddr_o), 32'(mExp.ra));
        end
        chk("stall_len", 32'(stallCnt), 32'(mExp.stallLen));
        chk("err", 32'(err_o), 32'(errSticky | mExp.tmo));
        errSticky = errSticky | mExp.setErr;
      end
      stallCnt = 0;
    end
  end

  // memory responder: acks in the ackDelay-th request cycle, noise otherwise
  int reqCnt = 0;
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      reqCnt = 0;
      mem_ack_i = 1'b0;
    end else if (mem_req_o) begin
      reqCnt++;
      chk("mem_addr", mem_addr_o, expAddr);
      chk("mem_we", 32'(mem_we_o), 32'(expWe));
      if (expWe) chk("mem_wdata", mem_wdata_o, expWdata);
      mem_ack_i = (reqCnt == ackDelay);
      mem_rdata_i = (reqCnt == ackDelay) ? ackData : $urandom;
    end else begin
      if (reqCnt > 0) chk("req_len", 32'(reqCnt), 32'(expReqLen));
      reqCnt = 0;
      mem_ack_i = ($urandom_range(0, 3) == 0);
      mem_rdata_i = $urandom;
    end
  end

  task automatic issue(input logic rd, input logic wr,
                       input logic [1:0] wb, input logic [31:0] alu,
                       input logic [31:0] wd, input logic [4:0] ra,
                       input int dly, input logic [31:0] rdat);
    exp_t e;
    bit mem, mis, ack, done;
    @(posedge clk_i);
    #1;
    mem = rd | wr;
    mis = mem && (alu[1:0] != 2'b00);
    ack = (dly >= 1) && (dly <= MW);
    e.wb = wb; e.md = '0; e.rd = alu; e.ra = ra;
    e.stallLen = 0; e.chkData = 1'b1; e.setErr = 1'b0; e.tmo = 1'b0;
    if (mis) begin
      e.wb = 2'b00; e.chkData = 1'b0; e.setErr = 1'b1;
    end else if (mem) begin
      e.stallLen = ack ? dly + 1 : MW + 1;
      if (!ack) begin
        e.wb = 2'b00; e.md = 32'hDEADBEEF; e.setErr = 1'b1; e.tmo = 1'b1;
      end else if (!wr) begin
        e.md = rdat;
      end
      expAddr = {alu[31:2], 2'b00};
      expWe = wr;
      expWdata = wd;
      ackDelay = dly;
      ackData = rdat;
      expReqLen = ack ? dly : MW;
    end
    MemRead_i = rd; MemWrite_i = wr; WB_i = wb;
    ALUResult_i = alu; WriteData_i = wd; RegAddr_i = ra;
    q.push_back(e);
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      @(negedge clk_i);
      if (!stall_o) done = 1'b1;
    end
    if (!done) begin
      vectors++;
      miscompares++;
      $display("FAIL retire_wait: stall_o got 1 want 0 within 40 cycles");
      q.delete();
    end
  endtask

  logic        rRd, rWr;
  logic [1:0]  rWb;
  logic [31:0] rAlu, rWd, rData;
  logic [4:0]  rRa;
  int          rOp, rDly;

  initial begin
    MemRead_i = 1'b1; WB_i = 2'b11;
    ALUResult_i = 32'h1234_5678; RegAddr_i = 5'd9;
    #3;
    chk("rst_wb", 32'(WB_o), 32'h0);
    chk("rst_stall", 32'(stall_o), 32'h0);
    chk("rst_memdata", MemData_o, 32'h0);
    chk("rst_regdata", RegData_o, 32'h0);
    chk("rst_regaddr", 32'(RegAddr_o), 32'h0);
    chk("rst_req", 32'(mem_req_o), 32'h0);
    chk("rst_err", 32'(err_o), 32'h0);
    MemRead_i = 1'b0; WB_i = 2'b00; ALUResult_i = '0; RegAddr_i = '0;
    @(posedge clk_i);
    @(posedge clk_i);
    #1 rst_ni = 1'b1;

    issue(1'b0, 1'b0, 2'b01, 32'h1234, 32'h0, 5'd5, 0, 32'h0);
    issue(1'b1, 1'b0, 2'b11, 32'h40, 32'h0, 5'd7, 1, 32'hCAFEF00D);
    issue(1'b0, 1'b1, 2'b00, 32'h80, 32'hA5A5A5A5, 5'd0, 3, 32'h0);
    issue(1'b1, 1'b0, 2'b11, 32'h42, 32'h0, 5'd3, 1, 32'h0);
    issue(1'b0, 1'b0, 2'b01, 32'h55, 32'h0, 5'd2, 0, 32'h0);
    issue(1'b1, 1'b0, 2'b11, 32'h200, 32'h0, 5'd4, 0, 32'h0);

    // abort a load mid-access with an asynchronous reset
    @(posedge clk_i);
    #1;
    expAddr = 32'h100; expWe = 1'b0; ackDelay = 0;
    MemRead_i = 1'b1; MemWrite_i = 1'b0; WB_i = 2'b11;
    ALUResult_i = 32'h100; RegAddr_i = 5'd8;
    repeat (3) @(negedge clk_i);
    #2 rst_ni = 1'b0;
    #1;
    chk("abort_req", 32'(mem_req_o), 32'h0);
    chk("abort_stall", 32'(stall_o), 32'h0);
    chk("abort_wb", 32'(WB_o), 32'h0);
    chk("abort_err", 32'(err_o), 32'h0);
    MemRead_i = 1'b0;
    @(posedge clk_i);
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
    errSticky = 1'b0;
    issue(1'b1, 1'b0, 2'b01, 32'h44, 32'h0, 5'd6, 2, 32'h0BADF00D);

    for (int n = 0; n < 150; n++) begin
      rOp = $urandom_range(0, 3);
      rRd = (rOp == 1) || (rOp == 3);
      rWr = (rOp >= 2);
      rWb = 2'($urandom);
      rAlu = $urandom;
      if ($urandom_range(0, 3) != 0) rAlu[1:0] = 2'b00;
      rWd = $urandom;
      rRa = 5'($urandom);
      rDly = $urandom_range(0, MW + 1);
      rData = $urandom;
      issue(rRd, rWr, rWb, rAlu, rWd, rRa, rDly, rData);
    end

    repeat (3) @(negedge clk_i);
    chk("queue_empty", 32'(q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

MEM-stage access unit between the EX_MEM register and the MEM_WB register of the 5-stage pipeline. It issues loads and stores to an external data memory over a req/ack handshake, and stalls the upstream stages while an access is outstanding. Because MEM_WB has no enable, the unit sends bubbles (WB = 2'b00) downstream while stalled. It also enforces word alignment and an ack timeout.

## Interface
- MAX_WAIT, 255: cycles in BUSY without ack before the access is abandoned (1..255).
- clk_i  in  1  clock; all state changes on posedge.
- rst_ni  in  1  reset, asynchronous, active-low.
- MemRead_i  in  1  load request from EX_MEM.
- MemWrite_i  in  1  store request from EX_MEM.
- WB_i  in  2  {MemtoReg, RegWrite} from EX_MEM.
- ALUResult_i  in  32  effective address, or ALU result for non-memory ops.
- WriteData_i  in  32  store data.
- RegAddr_i  in  5  destination register.
- WB_o  out  2  to MEM_WB WB_i.
- MemData_o  out  32  load data to MEM_WB.
- RegData_o  out  32  ALU result to MEM_WB.
- RegAddr_o  out  5  to MEM_WB.
- stall_o  out  1  hold PC, IF_ID, ID_EX and EX_MEM.
- mem_req_o  out  1  memory request, registered.
- mem_we_o  out  1  1 = store.
- mem_addr_o  out  32  word address, {addr[31:2],2'b00}.
- mem_wdata_o  out  32  store data.
- mem_ack_i  in  1  memory done; may be high in the same cycle as mem_req_o.
- mem_rdata_i  in  32  load data, valid when mem_ack_i = 1.
- err_o  out  1  sticky error: misaligned access or timeout.

## Operation
- The FSM has three states: IDLE, BUSY and DONE.
- Access condition: acc = MemRead_i | MemWrite_i. If both are set, the access is a store.
- IDLE, acc = 0:
  - Outputs pass through combinationally: WB_o = WB_i, RegData_o = ALUResult_i, RegAddr_o = RegAddr_i, MemData_o = 0.
  - stall_o = 0.
- IDLE, acc = 1, ALUResult_i[1:0] ≠ 0 (misaligned):
  - No request is issued and stall_o = 0.
  - WB_o = 2'b00 for this cycle.
  - err_o is set at the next edge.
- IDLE, acc = 1, aligned:
  - stall_o = 1 combinationally.
  - WB_o = 2'b00.
  - At the edge, capture WB, ALUResult, RegAddr and we. Load mem_addr_o and mem_wdata_o, set mem_req_o = 1, clear the counter, go to BUSY.
- BUSY:
  - stall_o = 1 and WB_o = 2'b00.
  - mem_req_o, mem_we_o, mem_addr_o and mem_wdata_o are held stable until ack.
  - On mem_ack_i = 1: capture mem_rdata_i (loads only; stores capture 0), drop mem_req_o, go to DONE.
  - Otherwise the counter increments. When it equals MAX_WAIT-1 with no ack: drop mem_req_o, capture MemData = 32'hDEADBEEF, force the captured WB to 2'b00, set err_o, go to DONE.
- DONE:
  - stall_o = 0.
  - Outputs come from the captured registers (WB, captured data, ALUResult, RegAddr).
  - Inputs are ignored, because EX_MEM still shows the completed instruction.
  - Return to IDLE unconditionally.
- mem_ack_i is ignored outside BUSY.
- err_o is cleared only by reset.

## Timing
- Reset (rst_ni low, asynchronous):
  - Registered outputs clear: state = IDLE, mem_req_o = 0, mem_we_o = 0, mem_addr_o = 0, mem_wdata_o = 0, captured registers = 0, counter = 0, err_o = 0.
  - Combinational outputs are forced while rst_ni is low: WB_o = 2'b00, stall_o = 0, MemData_o = 0, RegData_o = 0, RegAddr_o = 0.
- Reset mid-BUSY aborts the access: mem_req_o falls with no clock edge; nothing reaches writeback.
- Non-memory op: 0 added cycles.
- Memory op with ack in the first BUSY cycle: stall_o is high for 2 cycles (IDLE-detect and BUSY), DONE is the third. MEM_WB latches the result at the end of DONE.
- Ack after k BUSY cycles: stall_o high for k+1 cycles.
- Timeout: stall_o high for MAX_WAIT+1 cycles.
- Back-to-back memory ops: DONE → IDLE → a new access is detected one cycle after DONE.

## Test plan
- ALU op, WB_i = 2'b01, ALUResult_i = 32'h1234, RegAddr_i = 5 → same cycle WB_o = 2'b01, RegData_o = 32'h1234, RegAddr_o = 5, stall_o = 0.
- Load at 32'h40 with ack in the first BUSY cycle, mem_rdata_i = 32'hCAFEF00D:
  - mem_req_o is high 1 cycle and stall_o is high 2 cycles.
  - In DONE: WB_o = WB_i captured, MemData_o = 32'hCAFEF00D.
- Store at 32'h80 of 32'hA5A5A5A5 with ack delayed 3 cycles:
  - mem_we_o = 1, mem_addr_o = 32'h80 and mem_wdata_o are stable all 3 cycles.
  - stall_o high 4 cycles; WB_o = 2'b00 throughout.
- Load at 32'h42 → no mem_req_o, no stall, WB_o = 2'b00 for one cycle, err_o = 1 from the next cycle.
- MAX_WAIT = 4, load with no ack → mem_req_o drops after 4 BUSY cycles, DONE shows MemData_o = 32'hDEADBEEF with WB_o = 2'b00, err_o = 1.
- rst_ni pulsed low during BUSY → mem_req_o = 0 and stall_o = 0 immediately; after release, a new load completes normally and err_o = 0.
